// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that funnels per-channel read/write requests onto one
// single-port SRAM, serving one request at a time.
`ifndef DATA_MEMORY_ADDRESS_WIDTH
`define DATA_MEMORY_ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module data_mem_arbiter #(
  parameter int NUM_CHANNELS  = 8,
  parameter int ADDRESS_WIDTH = `DATA_MEMORY_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = `DATA_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CHANNELS-1:0]                   data_mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] data_mem_read_address,
  output logic [NUM_CHANNELS-1:0]                   data_mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    data_mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                   data_mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] data_mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    data_mem_write_data,
  output logic [NUM_CHANNELS-1:0]                   data_mem_write_ready,
  output logic                                      sram_en,
  output logic                                      sram_we,
  output logic [ADDRESS_WIDTH-1:0]                  sram_addr,
  output logic [DATA_WIDTH-1:0]                     sram_wdata,
  input  logic [DATA_WIDTH-1:0]                     sram_rdata,
  output logic                                      busy
);

  localparam int SLOTS = 2 * NUM_CHANNELS;
  localparam int SW    = $clog2(SLOTS);
  localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESPOND} state_t;

  state_t                                   state_q, state_d;
  logic [SW-1:0]                            rr_q, rr_d;
  logic                                     excl_vld_q, excl_vld_d;
  logic [SW-1:0]                            excl_slot_q, excl_slot_d;
  logic [SW-1:0]                            slot_q, slot_d;
  logic [ADDRESS_WIDTH-1:0]                 addr_q, addr_d;
  logic [DATA_WIDTH-1:0]                    wdata_q, wdata_d;
  logic                                     sram_en_q, sram_en_d;
  logic                                     sram_we_q, sram_we_d;
  logic                                     busy_q, busy_d;
  logic [NUM_CHANNELS-1:0]                  rrdy_q, rrdy_d;
  logic [NUM_CHANNELS-1:0]                  wrdy_q, wrdy_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  rdata_q, rdata_d;

  // Slot 2*ch is the read, 2*ch+1 the write of channel ch.
  logic [SLOTS-1:0] req, req_m;
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_req
    assign req[2*c]   = data_mem_read_valid[c];
    assign req[2*c+1] = data_mem_write_valid[c];
  end

  // The slot just completed is hidden for one IDLE cycle so a held valid is not re-served.
  assign req_m = req & ~(excl_vld_q ? (SLOTS'(1) << excl_slot_q) : '0);

  logic [SLOTS-1:0][SW-1:0] ord;
  for (genvar i = 0; i < SLOTS; i++) begin : g_ord
    assign ord[i] = SW'((int'(rr_q) + i) % SLOTS);
  end

  logic          gnt_vld;
  logic [SW-1:0] gnt_slot;
  logic [CW-1:0] gnt_ch, cur_ch;
  logic          gnt_wr, cur_wr;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_slot = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (req_m[ord[i]]) begin
        gnt_vld  = 1'b1;
        gnt_slot = ord[i];
      end
    end
  end

  assign gnt_ch = CW'(gnt_slot >> 1);
  assign gnt_wr = gnt_slot[0];
  assign cur_ch = CW'(slot_q >> 1);
  assign cur_wr = slot_q[0];

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    excl_vld_d  = excl_vld_q;
    excl_slot_d = excl_slot_q;
    slot_d      = slot_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sram_en_d   = 1'b0;
    sram_we_d   = 1'b0;
    rrdy_d      = '0;
    wrdy_d      = '0;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        excl_vld_d = 1'b0;
        if (gnt_vld) begin
          state_d   = S_ACCESS;
          rr_d      = (gnt_slot == SW'(SLOTS - 1)) ? '0 : gnt_slot + SW'(1);
          slot_d    = gnt_slot;
          addr_d    = gnt_wr ? data_mem_write_address[gnt_ch] : data_mem_read_address[gnt_ch];
          wdata_d   = gnt_wr ? data_mem_write_data[gnt_ch] : '0;
          sram_en_d = 1'b1;
          sram_we_d = gnt_wr;
        end
      end
      S_ACCESS: begin
        if (cur_wr) begin
          state_d        = S_RESPOND;
          wrdy_d[cur_ch] = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rdata_d[cur_ch] = sram_rdata;
        rrdy_d[cur_ch]  = 1'b1;
        state_d         = S_RESPOND;
      end
      S_RESPOND: begin
        state_d     = S_IDLE;
        excl_vld_d  = 1'b1;
        excl_slot_d = slot_q;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      excl_vld_q  <= 1'b0;
      excl_slot_q <= '0;
      slot_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sram_en_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      rrdy_q      <= '0;
      wrdy_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      excl_vld_q  <= excl_vld_d;
      excl_slot_q <= excl_slot_d;
      slot_q      <= slot_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sram_en_q   <= sram_en_d;
      sram_we_q   <= sram_we_d;
      busy_q      <= busy_d;
      rrdy_q      <= rrdy_d;
      wrdy_q      <= wrdy_d;
      rdata_q     <= rdata_d;
    end
  end

  assign sram_en              = sram_en_q;
  assign sram_we              = sram_we_q;
  assign sram_addr            = addr_q;
  assign sram_wdata           = wdata_q;
  assign busy                 = busy_q;
  assign data_mem_read_ready  = rrdy_q;
  assign data_mem_write_ready = wrdy_q;
  assign data_mem_read_data   = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: single-port SRAM model, ready-pulse log,
// hand-computed expectations for timing, ordering and reset behaviour.
module tb_data_mem_arbiter;
  localparam int N  = 8;
  localparam int AW = 8;
  localparam int DW = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N-1:0]          rv, wv, rrdy, wrdy;
  logic [N-1:0][AW-1:0]  ra, wa;
  logic [N-1:0][DW-1:0]  rd, wd;
  logic                  sram_en, sram_we, busy;
  logic [AW-1:0]         sram_addr;
  logic [DW-1:0]         sram_wdata, sram_rdata;
  logic                  preload = 1'b1;
  logic [DW-1:0]         mem [256];
  int                    total = 0, bad = 0, cyc = 0;
  int                    log_slot[$];
  int                    log_cyc[$];

  data_mem_arbiter #(.NUM_CHANNELS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .data_mem_read_valid(rv), .data_mem_read_address(ra),
    .data_mem_read_ready(rrdy), .data_mem_read_data(rd),
    .data_mem_write_valid(wv), .data_mem_write_address(wa), .data_mem_write_data(wd),
    .data_mem_write_ready(wrdy),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) mem[8'h10] <= 16'hBEEF;
    else if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (rrdy[c]) begin log_slot.push_back(2*c);   log_cyc.push_back(cyc); end
      if (wrdy[c]) begin log_slot.push_back(2*c+1); log_cyc.push_back(cyc); end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles, dropping each request as soon as its ready pulse is seen.
  task automatic run_drop(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (rrdy[c]) rv[c] = 1'b0;
        if (wrdy[c]) wv[c] = 1'b0;
      end
    end
  endtask

  initial begin
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    @(negedge clk);
    preload = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en",    sram_en,   1'b0);
    chk("rst_we",    sram_we,   1'b0);
    chk("rst_addr",  sram_addr, 8'h00);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_rrdy",  rrdy,      8'h00);
    chk("rst_wrdy",  wrdy,      8'h00);
    chk("rst_rdata", rd,        128'h0);
    reset = 1'b0;

    // single read on channel 2
    rv[2] = 1'b1; ra[2] = 8'h10;
    @(negedge clk);
    chk("rd_en",   sram_en,   1'b1);
    chk("rd_we",   sram_we,   1'b0);
    chk("rd_addr", sram_addr, 8'h10);
    chk("rd_busy", busy,      1'b1);
    @(negedge clk);
    chk("rd_wait_en", sram_en, 1'b0);
    chk("rd_early",   rrdy,    8'h00);
    @(negedge clk);
    chk("rd_rdy",  rrdy,  8'h04);
    chk("rd_data", rd[2], 16'hBEEF);
    @(negedge clk);
    chk("rd_pulse", rrdy, 8'h00);
    chk("rd_idle",  busy, 1'b0);
    @(negedge clk);
    chk("rd_excl", busy, 1'b0);
    rv[2] = 1'b0;

    // single write on channel 5
    wv[5] = 1'b1; wa[5] = 8'h20; wd[5] = 16'h1234;
    @(negedge clk);
    chk("wr_en",    sram_en,    1'b1);
    chk("wr_we",    sram_we,    1'b1);
    chk("wr_addr",  sram_addr,  8'h20);
    chk("wr_wdata", sram_wdata, 16'h1234);
    @(negedge clk);
    chk("wr_rdy", wrdy, 8'h20);
    wv[5] = 1'b0;
    @(negedge clk);
    chk("wr_pulse", wrdy, 8'h00);
    chk("wr_mem",   mem[8'h20], 16'h1234);

    // read back on channel 0
    rv[0] = 1'b1; ra[0] = 8'h20;
    repeat (3) @(negedge clk);
    chk("rb_rdy",   rrdy,  8'h01);
    chk("rb_data",  rd[0], 16'h1234);
    chk("rb_keep2", rd[2], 16'hBEEF);
    rv[0] = 1'b0;
    repeat (2) @(negedge clk);

    // fairness: every channel reads, valids held from reset
    reset = 1'b1;
    rv = '1;
    for (int c = 0; c < N; c++) ra[c] = AW'(c);
    repeat (2) @(negedge clk);
    chk("fair_rst_data", rd,   128'h0);
    chk("fair_rst_busy", busy, 1'b0);
    log_slot.delete(); log_cyc.delete();
    reset = 1'b0;
    repeat (31) @(negedge clk);
    chk("fair_last", rrdy, 8'h80);
    rv = '0;
    repeat (3) @(negedge clk);
    chk("fair_n", log_slot.size(), 8);
    for (int i = 0; i < 8 && i < log_slot.size(); i++) begin
      chk($sformatf("fair_slot%0d", i), log_slot[i], 2*i);
      chk($sformatf("fair_gap%0d", i), log_cyc[i] - log_cyc[0], 4*i);
    end
    chk("fair_idle", busy, 1'b0);

    // wrap: pointer sits at 15, read7 and write0 pending
    log_slot.delete(); log_cyc.delete();
    rv[7] = 1'b1; ra[7] = 8'h10;
    wv[0] = 1'b1; wa[0] = 8'h30; wd[0] = 16'hA5A5;
    run_drop(20);
    chk("wrap_n", log_slot.size(), 2);
    if (log_slot.size() >= 2) begin
      chk("wrap_first",  log_slot[0], 1);
      chk("wrap_second", log_slot[1], 14);
    end
    chk("wrap_rd7", rd[7],      16'hBEEF);
    chk("wrap_mem", mem[8'h30], 16'hA5A5);

    // same-channel read and write from pointer 0
    reset = 1'b1;
    repeat (2) @(negedge clk);
    log_slot.delete(); log_cyc.delete();
    rv[3] = 1'b1; ra[3] = 8'h10;
    wv[3] = 1'b1; wa[3] = 8'h40; wd[3] = 16'h5A5A;
    reset = 1'b0;
    run_drop(20);
    chk("same_n", log_slot.size(), 2);
    if (log_slot.size() >= 2) begin
      chk("same_first",  log_slot[0], 6);
      chk("same_second", log_slot[1], 7);
    end
    chk("same_rd3", rd[3],      16'hBEEF);
    chk("same_mem", mem[8'h40], 16'h5A5A);

    // reset while the read is in WAIT
    rv[1] = 1'b1; ra[1] = 8'h10;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_wait_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_rrdy", rrdy,    8'h00);
    chk("mrst_data", rd,      128'h0);
    chk("mrst_busy", busy,    1'b0);
    chk("mrst_en",   sram_en, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_re_en",   sram_en,   1'b1);
    chk("mrst_re_addr", sram_addr, 8'h10);
    repeat (2) @(negedge clk);
    chk("mrst_re_rdy",  rrdy,  8'h02);
    chk("mrst_re_data", rd[1], 16'hBEEF);
    rv[1] = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
